track_decoder: RTL
==================

# track_decoder

Parametrised per-channel track decoder for the S/PDIF Radio transmitter, sitting between the shared storage reader and the channel sample path. It locates its channel's track table, announces each track's artist/title into the shared text buffer under mutex, and streams little-endian PCM samples of configurable width. Compared with the first-generation decoder it adds configurable channel count, sample width and text depth, Restart, Loop/Stop end-of-table handling, text truncation, a sample strobe and a track counter.

## Interface

- Channel, 0: channel index; selects the start-block pointer in the directory.
- Channel_Bits, 3: width of Channel; up to 2^Channel_Bits channels.
- Block_Width, 32: block-index width; byte address width AW = Block_Width+9.
- Sample_Bytes, 2: bytes per sample, 1..4; SW = 8*Sample_Bytes.
- Text_Width, 7: text buffer address width.

- Clk  in  1  system clock; all logic rising-edge.
- nReset  in  1  asynchronous, active-low reset.
- Clk_Ena  in  1  byte-rate enable.
- Address  out  AW  byte address requested from storage.
- Data  in  8  byte at Address.
- Data_Valid  in  1  Data is valid for the current Address.
- Text_Mutex_Request  out  1  request for the shared text buffer.
- Text_Mutex_Grant  in  1  text buffer granted.
- Text_Address  out  Text_Width  text write address.
- Text_Data  out  8  text write byte.
- Text_Enable  out  1  text write strobe.
- Skip  in  1  advance to the next track.
- Restart  in  1  replay the current track from its length field.
- Loop  in  1  1: wrap to the first track at end of table; 0: stop.
- Output  out  SW  current sample.
- Output_Valid  out  1  one-cycle pulse when Output updates.
- Track_Number  out  8  index of the playing track, 0-based; wraps at 255.

## Operation

- A byte is accepted when Clk_Ena & Data_Valid. Address advances by 1 per accepted byte unless stated otherwise.
- Storage format:
  - Directory: 4-byte little-endian start block per channel, located at byte Channel*4.
  - First track: starts at Start_Block<<9.
  - Each track: 4-byte little-endian length L, then artist, NUL, title, NUL, then samples. L counts bytes after the last length byte.
  - L = 0 marks end of table.
- States:
  - Start: reads 4 directory bytes. Latches Start_Block. Sets Address = Start_Block<<9 and Track_Start = same. Next state ReadLength.
  - ReadLength: reads 4 bytes. If L != 0: Track_End = (address of last length byte) + L, modulo 2^AW; Text_Address = all-ones; Text_Mutex_Request = 1; next state WaitGrant.
  - ReadLength with L = 0: if Loop, Address = Start_Block<<9, Track_Number = 0, stay in ReadLength. Otherwise go to Stopped with Output = 0.
  - WaitGrant: consumes nothing until Text_Mutex_Grant is high, then moves to ReadArtist.
  - ReadArtist / ReadTitle: for each accepted byte, Text_Data = Data and Text_Address++. Text_Enable = 1 only while Text_Address has not saturated at all-ones after the first write. Bytes past capacity are consumed but not written. A NUL byte moves ReadArtist to ReadTitle, and ReadTitle to ReadSound.
  - ReadSound: Text_Enable = 0 and Text_Mutex_Request = 0 on the first cycle. Bytes are assembled little-endian. When the Sample_Bytes-th byte is accepted: Output updates and Output_Valid pulses. When the accepted byte's address equals Track_End: any partial sample is discarded, Track_Number++, Track_Start = Track_End+1, next state ReadLength.
  - Stopped: idle. Output = 0, mutex released.
- Skip (level, not in Start or Stopped):
  - Address = Track_End+1, Track_Start = same.
  - Mutex and Text_Enable released; Output = 0; byte counter cleared; Track_Number++.
  - Next state ReadLength.
- Restart (not in Start):
  - Address = Track_Start; same clears as Skip; Track_Number unchanged.
  - In Stopped: Address = Start_Block<<9, Track_Number = 0.
- Priority: nReset > Skip > Restart > byte processing. Skip and Restart act regardless of Clk_Ena and Data_Valid.

## Timing

- Reset values:
  - Address = Channel*4.
  - All other outputs and Track_Number = 0; state Start.
- Address is registered and updates the cycle after acceptance. Storage must not assert Data_Valid for a stale Address.
- Output / Output_Valid: registered, one cycle after the final sample byte is accepted. Output holds its value between pulses.
- Text writes: one cycle after the byte is accepted. Text_Enable is not re-cleared between consecutive writes.
- Mutex: Text_Mutex_Request rises one cycle after the last length byte. It falls one cycle after the first ReadSound cycle, or on Skip/Restart/Stopped.
- Reset deassertion mid-track: restarts from the directory.

## Test plan

- Directory at 0x0C = {0x01,0,0,0}, Channel=3, Sample_Bytes=2 -> Address jumps to 0x200; track L=8, artist "A", title "B", samples 34 12 78 56 -> Output 0x1234 then 0x5678, each with a single Output_Valid pulse, then reads the next length at 0x20C.
- Sample_Bytes=3, L leaves 2 trailing bytes -> trailing partial sample is dropped, no extra Output_Valid pulse, Track_Number increments.
- Text_Width=2, artist of 6 bytes -> exactly 4 writes at addresses 0..3; remaining bytes consumed with Text_Enable low.
- Grant held low for 20 cycles -> Address frozen, no text writes; grant high -> writes resume starting at address 0.
- Zero-length table end: Loop=1 -> Address = Start_Block<<9, Track_Number = 0; Loop=0 -> Stopped, Output = 0; then Restart -> replays the first track.
- Skip and Restart asserted together in ReadArtist -> Skip wins: mutex released next cycle, Address = Track_End+1; asserting nReset low mid-sample -> all outputs clear asynchronously.

Source files
------------

// File: rtl/track_decoder.sv
// track_decoder: per-channel track table walker that publishes artist/title text and streams little-endian PCM samples.
module track_decoder #(
    parameter int Channel      = 0,
    parameter int Channel_Bits = 3,
    parameter int Block_Width  = 32,
    parameter int Sample_Bytes = 2,
    parameter int Text_Width   = 7,
    localparam int AW = Block_Width + 9,
    localparam int SW = 8 * Sample_Bytes
) (
    input  logic                  Clk,
    input  logic                  nReset,
    input  logic                  Clk_Ena,
    output logic [AW-1:0]         Address,
    input  logic [7:0]            Data,
    input  logic                  Data_Valid,
    output logic                  Text_Mutex_Request,
    input  logic                  Text_Mutex_Grant,
    output logic [Text_Width-1:0] Text_Address,
    output logic [7:0]            Text_Data,
    output logic                  Text_Enable,
    input  logic                  Skip,
    input  logic                  Restart,
    input  logic                  Loop,
    output logic [SW-1:0]         Output,
    output logic                  Output_Valid,
    output logic [7:0]            Track_Number
);
    typedef enum logic [2:0] {
        START, READ_LENGTH, WAIT_GRANT, READ_ARTIST, READ_TITLE, READ_SOUND, STOPPED
    } state_t;

    localparam logic [Channel_Bits-1:0] CH = Channel_Bits'(Channel);
    localparam logic [AW-1:0] DIR_ADDR = AW'(CH) << 2;

    state_t                  state_q, state_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [AW-1:0]           track_start_q, track_start_d;
    logic [AW-1:0]           track_end_q, track_end_d;
    logic [Block_Width-1:0]  start_block_q, start_block_d;
    logic [23:0]             sh_q, sh_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [Text_Width-1:0]   text_addr_q, text_addr_d;
    logic [7:0]              text_data_q, text_data_d;
    logic [7:0]              track_q, track_d;
    logic                    text_en_q, text_en_d;
    logic                    req_q, req_d;
    logic                    wrote_q, wrote_d;
    logic                    ov_q, ov_d;
    logic [SW-1:0]           out_q, out_d;

    logic                    accept, writable, sample_done, skip_act, restart_act;
    logic [31:0]             word;
    logic [AW-1:0]           first_track, dir_track;

    assign accept      = Clk_Ena & Data_Valid;
    // Bytes shift in from the top so the first byte ends up least significant.
    assign word        = {Data, sh_q};
    assign first_track = {start_block_q, 9'd0};
    assign dir_track   = {Block_Width'(word), 9'd0};
    // Address starts at all-ones, so the first write wraps to 0 and only a later all-ones means full.
    assign writable    = !(wrote_q && text_addr_q == '1);
    assign sample_done = cnt_q == 2'(Sample_Bytes - 1);
    assign skip_act    = Skip && state_q != START && state_q != STOPPED;
    assign restart_act = Restart && state_q != START;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        track_start_d = track_start_q;
        track_end_d   = track_end_q;
        start_block_d = start_block_q;
        sh_d          = sh_q;
        cnt_d         = cnt_q;
        text_addr_d   = text_addr_q;
        text_data_d   = text_data_q;
        track_d       = track_q;
        text_en_d     = text_en_q;
        req_d         = req_q;
        wrote_d       = wrote_q;
        ov_d          = 1'b0;
        out_d         = out_q;
        if (state_q == WAIT_GRANT && Text_Mutex_Grant)
            state_d = READ_ARTIST;
        if (state_q == READ_SOUND) begin
            req_d     = 1'b0;
            text_en_d = 1'b0;
        end
        if (accept && state_q != WAIT_GRANT && state_q != STOPPED) begin
            addr_d = addr_q + 1'b1;
            sh_d   = word[31:8];
            case (state_q)
                START: begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        start_block_d = Block_Width'(word);
                        addr_d        = dir_track;
                        track_start_d = dir_track;
                        state_d       = READ_LENGTH;
                    end
                end
                READ_LENGTH: begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (word != 32'd0) begin
                            track_end_d = addr_q + AW'(word);
                            text_addr_d = '1;
                            wrote_d     = 1'b0;
                            req_d       = 1'b1;
                            state_d     = WAIT_GRANT;
                        end else if (Loop) begin
                            addr_d        = first_track;
                            track_start_d = first_track;
                            track_d       = 8'd0;
                        end else begin
                            out_d   = '0;
                            req_d   = 1'b0;
                            state_d = STOPPED;
                        end
                    end
                end
                READ_ARTIST, READ_TITLE: begin
                    text_data_d = Data;
                    text_en_d   = writable;
                    if (writable) begin
                        text_addr_d = text_addr_q + 1'b1;
                        wrote_d     = 1'b1;
                    end
                    if (Data == 8'd0)
                        state_d = (state_q == READ_ARTIST) ? READ_TITLE : READ_SOUND;
                end
                READ_SOUND: begin
                    cnt_d = sample_done ? 2'd0 : cnt_q + 2'd1;
                    if (sample_done) begin
                        out_d = word[31 -: SW];
                        ov_d  = 1'b1;
                    end
                    if (addr_q == track_end_q) begin
                        cnt_d         = 2'd0;
                        track_d       = track_q + 8'd1;
                        track_start_d = track_end_q + 1'b1;
                        state_d       = READ_LENGTH;
                    end
                end
                default: ;
            endcase
        end
        if (skip_act || restart_act) begin
            req_d     = 1'b0;
            text_en_d = 1'b0;
            out_d     = '0;
            ov_d      = 1'b0;
            cnt_d     = 2'd0;
            state_d   = READ_LENGTH;
            if (skip_act) begin
                addr_d        = track_end_q + 1'b1;
                track_start_d = track_end_q + 1'b1;
                track_d       = track_q + 8'd1;
            end else if (state_q == STOPPED) begin
                addr_d        = first_track;
                track_start_d = first_track;
                track_d       = 8'd0;
            end else begin
                addr_d        = track_start_q;
                track_start_d = track_start_q;
                track_d       = track_q;
            end
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q       <= START;
            addr_q        <= DIR_ADDR;
            track_start_q <= '0;
            track_end_q   <= '0;
            start_block_q <= '0;
            sh_q          <= '0;
            cnt_q         <= '0;
            text_addr_q   <= '0;
            text_data_q   <= '0;
            track_q       <= '0;
            text_en_q     <= 1'b0;
            req_q         <= 1'b0;
            wrote_q       <= 1'b0;
            ov_q          <= 1'b0;
            out_q         <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            track_start_q <= track_start_d;
            track_end_q   <= track_end_d;
            start_block_q <= start_block_d;
            sh_q          <= sh_d;
            cnt_q         <= cnt_d;
            text_addr_q   <= text_addr_d;
            text_data_q   <= text_data_d;
            track_q       <= track_d;
            text_en_q     <= text_en_d;
            req_q         <= req_d;
            wrote_q       <= wrote_d;
            ov_q          <= ov_d;
            out_q         <= out_d;
        end
    end

    assign Address            = addr_q;
    assign Text_Mutex_Request = req_q;
    assign Text_Address       = text_addr_q;
    assign Text_Data          = text_data_q;
    assign Text_Enable        = text_en_q;
    assign Output             = out_q;
    assign Output_Valid       = ov_q;
    assign Track_Number       = track_q;
endmodule
